// File: rtl/store_decider_pkg.sv
// Shared encodings for the load/store data paths: access-size selectors and
// the store sequencer state type.
package store_decider_pkg;

    localparam logic [1:0] SEL_BYTE    = 2'b00;
    localparam logic [1:0] SEL_HALF    = 2'b01;
    localparam logic [1:0] SEL_WORD    = 2'b10;
    localparam logic [1:0] SEL_ILLEGAL = 2'b11;

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/store_decider_merge.sv
// Combinational lane merge for sub-word stores: the low byte or half of the
// register data replaces the matching low lane of the fetched memory word.
module store_merge
    import store_decider_pkg::*;
(
    input  logic [1:0]  selector,
    input  logic [31:0] rdata,
    input  logic [31:0] store_data,
    output logic [31:0] merged
);

    always_comb begin
        merged = store_data;
        case (selector)
            SEL_BYTE: merged = {rdata[31:8], store_data[7:0]};
            SEL_HALF: merged = {rdata[31:16], store_data[15:0]};
            default:  merged = store_data;
        endcase
    end

endmodule

// File: rtl/store_decider.sv
// Store sequencer: sw writes directly; sb/sh fetch the word, merge the low
// lane and write it back. start/done handshake towards the control unit.
module store_decider
    import store_decider_pkg::*;
#(
    parameter int unsigned MEM_READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  selector,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    output logic        busy,
    output logic        done,
    output logic        error
);

    // Handshake: start is a request sampled only in IDLE; done pulses for one
    // cycle at completion and requests arriving while busy are dropped.
    state_e             state;
    logic [1:0]         sel_q;
    logic [31:0]        data_q;
    logic [CNT_W-1:0]   wait_cnt;
    logic               error_q;
    logic [31:0]        merged;

    store_merge u_merge (
        .selector   (sel_q),
        .rdata      (mem_rdata),
        .store_data (data_q),
        .merged     (merged)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sel_q     <= SEL_BYTE;
            data_q    <= '0;
            wait_cnt  <= '0;
            error_q   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr <= addr;
                        sel_q    <= selector;
                        data_q   <= store_data;
                        error_q  <= 1'b0;
                        case (selector)
                            SEL_WORD: begin
                                mem_wdata <= store_data;
                                state     <= WRITE;
                            end
                            SEL_BYTE, SEL_HALF: begin
                                wait_cnt <= CNT_W'(MEM_READ_LATENCY - 1);
                                state    <= READ;
                            end
                            default: begin
                                error_q <= 1'b1;
                                state   <= DONE;
                            end
                        endcase
                    end
                end
                READ: begin
                    // mem_rdata is only trusted on the last cycle of the wait
                    if (wait_cnt == '0) begin
                        mem_wdata <= merged;
                        state     <= WRITE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                WRITE: state <= DONE;
                DONE: begin
                    error_q <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_wr = (state == WRITE);
    assign done   = (state == DONE);
    assign busy   = (state != IDLE);
    assign error  = error_q;

endmodule

// File: tb/tb_store_decider.sv
// Bench for store_decider: two instances (read latency 1 and 3) share stimulus
// and are checked each cycle against a per-request timeline and word memory.
module tb_store_decider;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  selector;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] rdata     [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic        mem_wr    [2];
    logic        busy      [2];
    logic        done      [2];
    logic        error     [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        store_decider #(.MEM_READ_LATENCY(g == 0 ? 1 : 3)) dut (
            .clock      (clock),
            .reset      (reset),
            .start      (start),
            .selector   (selector),
            .addr       (addr),
            .store_data (store_data),
            .mem_rdata  (rdata[g]),
            .mem_addr   (mem_addr[g]),
            .mem_wdata  (mem_wdata[g]),
            .mem_wr     (mem_wr[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .error      (error[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // reference model: per instance, edges elapsed since acceptance plus the
    // offsets at which the write and done cycles must appear
    int          checks = 0;
    int          errors = 0;
    int          lat      [2] = '{1, 3};
    int          n        [2] = '{100, 100};
    int          wr_off   [2] = '{0, 0};
    int          done_off [2] = '{0, 0};
    bit          has_wr   [2] = '{0, 0};
    logic [1:0]  m_sel    [2];
    logic [31:0] m_addr   [2];
    logic [31:0] m_sd     [2];
    logic [31:0] mem      [2][32];
    int          exp_wr_cnt [2] = '{0, 0};
    int          obs_wr_cnt [2] = '{0, 0};

    task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[L%0d] observed=%h expected=%h", tag, lat[inst], obs, exp);
        end
    endtask

    function automatic logic [31:0] expected_word(input logic [1:0] sel, input logic [31:0] old,
                                                  input logic [31:0] sd);
        case (sel)
            2'b00:   return (old & 32'hFFFF_FF00) | (sd & 32'h0000_00FF);
            2'b01:   return (old & 32'hFFFF_0000) | (sd & 32'h0000_FFFF);
            default: return sd;
        endcase
    endfunction

    task automatic step();
        @(posedge clock);
        for (int i = 0; i < 2; i++) begin
            if (n[i] <= done_off[i]) begin
                n[i]++;
            end else if (start) begin
                n[i] = 0;
                m_sel[i] = selector;
                m_addr[i] = addr;
                m_sd[i] = store_data;
                has_wr[i] = (selector != 2'b11);
                wr_off[i] = (selector == 2'b10) ? 0 : lat[i];
                done_off[i] = (selector == 2'b11) ? 0 : wr_off[i] + 1;
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            bit e_busy, e_wr, e_done;
            e_busy = (n[i] <= done_off[i]);
            e_wr   = e_busy && has_wr[i] && (n[i] == wr_off[i]);
            e_done = (n[i] == done_off[i]);
            if (e_busy && (m_sel[i] == 2'b00 || m_sel[i] == 2'b01) && n[i] == lat[i] - 1)
                rdata[i] = mem[i][m_addr[i][4:0]];
            else
                rdata[i] = $urandom;
            chk("busy", i, 32'(busy[i]), 32'(e_busy));
            chk("mem_wr", i, 32'(mem_wr[i]), 32'(e_wr));
            chk("done", i, 32'(done[i]), 32'(e_done));
            chk("error", i, 32'(error[i]), 32'(e_done && m_sel[i] == 2'b11));
            if (e_busy) chk("mem_addr", i, mem_addr[i], m_addr[i]);
            if (mem_wr[i]) obs_wr_cnt[i]++;
            if (e_wr) begin
                logic [31:0] w;
                w = expected_word(m_sel[i], mem[i][m_addr[i][4:0]], m_sd[i]);
                chk("mem_wdata", i, mem_wdata[i], w);
                mem[i][m_addr[i][4:0]] = w;
                exp_wr_cnt[i]++;
            end
        end
    endtask

    task automatic scramble_inputs();
        selector = 2'($urandom);
        addr = $urandom;
        store_data = $urandom;
    endtask

    task automatic issue(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] d);
        selector = sel;
        addr = a;
        store_data = d;
        start = 1'b1;
        step();
        start = 1'b0;
        scramble_inputs();
    endtask

    task automatic run(input int k);
        for (int j = 0; j < k; j++) step();
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_mem_addr"}, i, mem_addr[i], 32'h0);
            chk({tag, "_mem_wdata"}, i, mem_wdata[i], 32'h0);
            chk({tag, "_mem_wr"}, i, 32'(mem_wr[i]), 32'h0);
            chk({tag, "_busy"}, i, 32'(busy[i]), 32'h0);
            chk({tag, "_done"}, i, 32'(done[i]), 32'h0);
            chk({tag, "_error"}, i, 32'(error[i]), 32'h0);
        end
    endtask

    task automatic mid_reset(input string tag);
        #2 reset = 1'b0;
        #1 check_all_zero(tag);
        for (int i = 0; i < 2; i++) n[i] = 100;
        #2 reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        selector = 2'b00;
        addr = '0;
        store_data = '0;
        rdata[0] = '0;
        rdata[1] = '0;
        for (int i = 0; i < 2; i++)
            for (int w = 0; w < 32; w++) mem[i][w] = $urandom;
        #3 check_all_zero("reset");
        #4 reset = 1'b1;
        run(2);

        // sw direct write
        issue(2'b10, 32'h0000_0040, 32'hDEAD_BEEF);
        run(3);

        // sb and sh merges into a known word
        mem[0][5] = 32'h1122_3344;
        mem[1][5] = 32'h1122_3344;
        issue(2'b00, 32'h0000_0005, 32'hAABB_CCDD);
        run(5);
        mem[0][6] = 32'h1122_3344;
        mem[1][6] = 32'h1122_3344;
        issue(2'b01, 32'h0000_0006, 32'h0000_BEEF);
        run(5);

        // illegal selector: done with error, no memory write
        issue(2'b11, 32'h0000_0007, 32'h1234_5678);
        run(3);

        // start pulse while busy, then start held across DONE
        issue(2'b00, 32'h0000_0008, 32'h0000_0055);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        selector = 2'b01;
        addr = 32'h0000_0009;
        store_data = 32'h0000_7777;
        run(4);
        start = 1'b0;
        scramble_inputs();
        run(8);

        // randomized traffic
        for (int r = 0; r < 300; r++) begin
            start = ($urandom_range(0, 2) == 0);
            scramble_inputs();
            step();
        end
        start = 1'b0;
        run(8);

        // reset while reading, then while writing, then a clean request
        issue(2'b01, 32'h0000_0003, $urandom);
        mid_reset("rst_read");
        run(6);
        issue(2'b10, 32'h0000_0004, $urandom);
        mid_reset("rst_write");
        run(6);
        issue(2'b00, 32'h0000_000A, $urandom);
        run(6);

        for (int i = 0; i < 2; i++) chk("wr_count", i, 32'(obs_wr_cnt[i]), 32'(exp_wr_cnt[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
